// File: rtl/apb_master.sv
// APB requester: takes one command at a time, runs SETUP -> ACCESS, and returns
// read data / error / timeout status on a valid-ready response port.
module apb_master #(
  parameter int DATA_WD = 32,
  parameter int ADDR_WD = 16,
  parameter int TIMEOUT = 64
) (
  input  logic               PCLK,
  input  logic               PRESET,
  input  logic               CMD_VALID,
  output logic               CMD_READY,
  input  logic               CMD_WRITE,
  input  logic [ADDR_WD-1:0] CMD_ADDR,
  input  logic [DATA_WD-1:0] CMD_WDATA,
  input  logic [3:0]         CMD_STRB,
  output logic               RSP_VALID,
  input  logic               RSP_READY,
  output logic [DATA_WD-1:0] RSP_RDATA,
  output logic [1:0]         RSP_ERR,
  output logic               RSP_TIMEOUT,
  output logic               PSEL,
  output logic               PENABLE,
  output logic               PWRITE,
  output logic [ADDR_WD-1:0] PADDR,
  output logic [DATA_WD-1:0] PWDATA,
  output logic [3:0]         PSTRB,
  input  logic               PREADY,
  input  logic [DATA_WD-1:0] PRDATA,
  input  logic [1:0]         PSLVERR
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);
  localparam bit          TIMEOUT_EN  = (TIMEOUT != 0);

  logic [1:0]  state;
  logic [15:0] wait_cnt;
  logic [15:0] wait_cnt_inc;
  logic        timed_out;

  // Saturating wait-counter increment; with the timeout enabled the counter
  // never gets past TIMEOUT because the transfer is aborted there.
  always_comb begin
    wait_cnt_inc = wait_cnt;
    if (wait_cnt != 16'hFFFF) begin
      wait_cnt_inc = wait_cnt + 16'd1;
    end else begin
      wait_cnt_inc = wait_cnt;
    end
    timed_out = TIMEOUT_EN && (wait_cnt_inc == TIMEOUT_CNT);
  end

  // All outputs are registered straight from the transition that enters a state.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state       <= ST_IDLE;
      wait_cnt    <= 16'd0;
      CMD_READY   <= 1'b0;
      RSP_VALID   <= 1'b0;
      RSP_RDATA   <= '0;
      RSP_ERR     <= 2'b00;
      RSP_TIMEOUT <= 1'b0;
      PSEL        <= 1'b0;
      PENABLE     <= 1'b0;
      PWRITE      <= 1'b0;
      PADDR       <= '0;
      PWDATA      <= '0;
      PSTRB       <= 4'b0000;
    end else begin
      case (state)
        ST_IDLE: begin
          if (CMD_VALID && CMD_READY) begin
            state     <= ST_SETUP;
            CMD_READY <= 1'b0;
            PSEL      <= 1'b1;
            PWRITE    <= CMD_WRITE;
            PADDR     <= CMD_ADDR;
            PWDATA    <= CMD_WDATA;
            PSTRB     <= CMD_WRITE ? CMD_STRB : 4'b0000;
          end else begin
            CMD_READY <= 1'b1;
          end
        end
        ST_SETUP: begin
          PENABLE <= 1'b1;
          state   <= ST_ACCESS;
        end
        ST_ACCESS: begin
          // PREADY takes priority over a timeout landing on the same cycle.
          if (PREADY) begin
            state       <= ST_RESP;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            RSP_VALID   <= 1'b1;
            RSP_ERR     <= PSLVERR;
            RSP_TIMEOUT <= 1'b0;
            RSP_RDATA   <= PWRITE ? '0 : PRDATA;
          end else begin
            wait_cnt <= wait_cnt_inc;
            if (timed_out) begin
              state       <= ST_RESP;
              PSEL        <= 1'b0;
              PENABLE     <= 1'b0;
              RSP_VALID   <= 1'b1;
              RSP_ERR     <= 2'b00;
              RSP_TIMEOUT <= 1'b1;
              RSP_RDATA   <= '0;
            end else begin
              state <= ST_ACCESS;
            end
          end
        end
        ST_RESP: begin
          if (RSP_READY) begin
            RSP_VALID <= 1'b0;
            wait_cnt  <= 16'd0;
            CMD_READY <= 1'b1;
            state     <= ST_IDLE;
          end else begin
            state <= ST_RESP;
          end
        end
        default: begin
          state     <= ST_IDLE;
          CMD_READY <= 1'b0;
          RSP_VALID <= 1'b0;
          PSEL      <= 1'b0;
          PENABLE   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master: directed scenarios plus randomized
// transfers against a transaction-level latency/response model.
module tb_apb_master;

  localparam int TMO = 16;

  typedef struct packed {
    logic [7:0]  lat;
    logic [31:0] rdata;
    logic [1:0]  err;
    logic        tmo;
  } rsp_t;

  logic        PCLK = 1'b0;
  logic        PRESET = 1'b1;
  logic        CMD_VALID = 1'b0;
  logic        CMD_READY;
  logic        CMD_WRITE = 1'b0;
  logic [15:0] CMD_ADDR = 16'd0;
  logic [31:0] CMD_WDATA = 32'd0;
  logic [3:0]  CMD_STRB = 4'd0;
  logic        RSP_VALID;
  logic        RSP_READY = 1'b0;
  logic [31:0] RSP_RDATA;
  logic [1:0]  RSP_ERR;
  logic        RSP_TIMEOUT;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [15:0] PADDR;
  logic [31:0] PWDATA;
  logic [3:0]  PSTRB;
  logic        PREADY = 1'b0;
  logic [31:0] PRDATA = 32'd0;
  logic [1:0]  PSLVERR = 2'd0;

  int nt = 0;
  int nf = 0;

  apb_master #(.DATA_WD(32), .ADDR_WD(16), .TIMEOUT(TMO)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_WRITE(CMD_WRITE),
    .CMD_ADDR(CMD_ADDR), .CMD_WDATA(CMD_WDATA), .CMD_STRB(CMD_STRB),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_RDATA(RSP_RDATA),
    .RSP_ERR(RSP_ERR), .RSP_TIMEOUT(RSP_TIMEOUT),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PSTRB(PSTRB), .PREADY(PREADY), .PRDATA(PRDATA),
    .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  // Expected response: a transfer whose slave would stall TMO or more cycles is aborted.
  function automatic rsp_t model(logic wr, logic [31:0] prd, logic [1:0] err, int waits);
    rsp_t m;
    if (TMO != 0 && waits >= TMO) begin
      m.lat = 8'(2 + TMO); m.rdata = 32'd0; m.err = 2'b00; m.tmo = 1'b1;
    end else begin
      m.lat = 8'(3 + waits); m.rdata = wr ? 32'd0 : prd; m.err = err; m.tmo = 1'b0;
    end
    return m;
  endfunction

  function automatic logic [91:0] all_outputs();
    return {CMD_READY, RSP_VALID, RSP_RDATA, RSP_ERR, RSP_TIMEOUT,
            PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB};
  endfunction

  // Runs one transfer; the slave raises PREADY on ACCESS cycle waits+1.
  // Returns the observed response and a count of protocol violations seen.
  task automatic do_txn(input logic wr, input logic [15:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, input int waits, input logic [31:0] prd,
                        input logic [1:0] err, input int rsp_delay, input bit keep_valid,
                        output rsp_t obs, output int viol, output int acc_wait);
    int cyc;
    int acc;
    bit done;
    viol = 0; acc_wait = 0; obs = '0;
    CMD_WRITE = wr; CMD_ADDR = addr; CMD_WDATA = wdata; CMD_STRB = strb; CMD_VALID = 1'b1;
    while (CMD_READY !== 1'b1 && acc_wait < 50) begin
      @(negedge PCLK);
      acc_wait++;
    end
    if (CMD_READY !== 1'b1) begin
      viol++;
      CMD_VALID = 1'b0;
    end else begin
      @(posedge PCLK);
      cyc = 0; acc = 0; done = 1'b0;
      while (!done && cyc < 200) begin
        @(negedge PCLK);
        cyc++;
        if (cyc == 1 && !keep_valid) CMD_VALID = 1'b0;
        if (RSP_VALID === 1'b1) begin
          done = 1'b1;
        end else begin
          if (cyc == 1) begin
            if (PSEL !== 1'b1 || PENABLE !== 1'b0) viol++;
          end else if (PSEL !== 1'b1 || PENABLE !== 1'b1) viol++;
          if (PADDR !== addr || PWDATA !== wdata || PWRITE !== wr ||
              PSTRB !== (wr ? strb : 4'b0000) || CMD_READY !== 1'b0) viol++;
          if (cyc >= 2) begin
            acc++;
            PREADY  = (acc == waits + 1);
            PRDATA  = PREADY ? prd : $urandom;
            PSLVERR = PREADY ? err : 2'($urandom);
          end else begin
            PREADY  = 1'($urandom);
            PRDATA  = $urandom;
            PSLVERR = 2'($urandom);
          end
        end
      end
      if (!done) begin
        viol++;
      end else begin
        obs.lat = 8'(cyc); obs.rdata = RSP_RDATA; obs.err = RSP_ERR; obs.tmo = RSP_TIMEOUT;
        PREADY = 1'($urandom); PSLVERR = 2'($urandom); PRDATA = $urandom;
        if (PSEL !== 1'b0 || PENABLE !== 1'b0 || CMD_READY !== 1'b0) viol++;
        for (int d = 0; d < rsp_delay; d++) begin
          RSP_READY = 1'b0;
          @(negedge PCLK);
          PREADY = 1'($urandom);
          if (RSP_VALID !== 1'b1 || RSP_RDATA !== obs.rdata || RSP_ERR !== obs.err ||
              RSP_TIMEOUT !== obs.tmo || CMD_READY !== 1'b0 || PSEL !== 1'b0) viol++;
        end
        RSP_READY = 1'b1;
        @(negedge PCLK);
        RSP_READY = 1'b0;
        PREADY = 1'b0;
        if (RSP_VALID !== 1'b0 || CMD_READY !== 1'b1) viol++;
      end
    end
  endtask

  task automatic test_reset();
    PRESET = 1'b1;
    repeat (2) @(posedge PCLK);
    @(negedge PCLK);
    nt++;
    if (all_outputs() !== 92'd0) begin
      nf++;
      $display("FAIL reset_outputs got %h want 0", all_outputs());
    end
    PRESET = 1'b0;
  endtask

  task automatic test_write();
    rsp_t obs, exp; int viol, aw;
    do_txn(1'b1, 16'd12, 32'd152, 4'b1111, 0, 32'd0, 2'b00, 0, 1'b0, obs, viol, aw);
    exp = model(1'b1, 32'd0, 2'b00, 0);
    nt++;
    if (obs !== exp) begin nf++; $display("FAIL write0_rsp got %h want %h", obs, exp); end
    nt++;
    if (viol !== 0) begin nf++; $display("FAIL write0_protocol got %0d violations want 0", viol); end
  endtask

  task automatic test_read_wait();
    rsp_t obs, exp; int viol, aw;
    do_txn(1'b0, 16'd34, 32'hDEAD_BEEF, 4'b1111, 3, 32'd150, 2'b00, 0, 1'b0, obs, viol, aw);
    exp = model(1'b0, 32'd150, 2'b00, 3);
    nt++;
    if (obs !== exp) begin nf++; $display("FAIL read3_rsp got %h want %h", obs, exp); end
    nt++;
    if (viol !== 0) begin nf++; $display("FAIL read3_protocol got %0d violations want 0", viol); end
  endtask

  task automatic test_slave_err();
    rsp_t obs, exp; int viol, aw;
    do_txn(1'b1, 16'd5, 32'h1234_5678, 4'b0011, 1, 32'd0, 2'b01, 1, 1'b0, obs, viol, aw);
    exp = model(1'b1, 32'd0, 2'b01, 1);
    nt++;
    if (obs !== exp) begin nf++; $display("FAIL slverr_rsp got %h want %h", obs, exp); end
    nt++;
    if (viol !== 0) begin nf++; $display("FAIL slverr_protocol got %0d violations want 0", viol); end
  endtask

  task automatic test_timeout();
    rsp_t obs, exp; int viol, aw;
    int waits_tab[3] = '{1000, TMO - 1, TMO};
    for (int k = 0; k < 3; k++) begin
      do_txn(1'b0, 16'(100 + k), $urandom, 4'b1111, waits_tab[k], 32'hCAFE_0000 + 32'(k),
             2'b10, 0, 1'b0, obs, viol, aw);
      exp = model(1'b0, 32'hCAFE_0000 + 32'(k), 2'b10, waits_tab[k]);
      nt++;
      if (obs !== exp) begin nf++; $display("FAIL timeout%0d_rsp got %h want %h", k, obs, exp); end
      nt++;
      if (viol !== 0) begin nf++; $display("FAIL timeout%0d_protocol got %0d violations want 0", k, viol); end
    end
  endtask

  task automatic test_backpressure();
    rsp_t obs, exp; int viol, aw;
    do_txn(1'b0, 16'h0040, 32'd0, 4'b1010, 2, 32'h0BAD_F00D, 2'b11, 5, 1'b1, obs, viol, aw);
    exp = model(1'b0, 32'h0BAD_F00D, 2'b11, 2);
    nt++;
    if (obs !== exp) begin nf++; $display("FAIL backpressure_rsp got %h want %h", obs, exp); end
    nt++;
    if (viol !== 0) begin nf++; $display("FAIL backpressure_protocol got %0d violations want 0", viol); end
    do_txn(1'b1, 16'h0044, 32'h5555_AAAA, 4'b0101, 0, 32'd0, 2'b00, 0, 1'b0, obs, viol, aw);
    exp = model(1'b1, 32'd0, 2'b00, 0);
    nt++;
    if (aw !== 0) begin nf++; $display("FAIL pending_accept got %0d wait cycles want 0", aw); end
    nt++;
    if (obs !== exp || viol !== 0) begin
      nf++;
      $display("FAIL pending_rsp got %h/%0d want %h/0", obs, viol, exp);
    end
  endtask

  task automatic test_reset_mid();
    rsp_t obs, exp; int viol, aw, k, bad;
    CMD_WRITE = 1'b0; CMD_ADDR = 16'd77; CMD_WDATA = $urandom; CMD_STRB = 4'hF;
    CMD_VALID = 1'b1; PREADY = 1'b0;
    k = 0;
    while (CMD_READY !== 1'b1 && k < 20) begin @(negedge PCLK); k++; end
    nt++;
    if (CMD_READY !== 1'b1) begin nf++; $display("FAIL rstmid_accept got %b want 1", CMD_READY); end
    @(posedge PCLK);
    @(negedge PCLK); CMD_VALID = 1'b0;
    @(negedge PCLK);
    @(negedge PCLK); PRESET = 1'b1;
    @(negedge PCLK); PRESET = 1'b0;
    nt++;
    if (all_outputs() !== 92'd0) begin
      nf++;
      $display("FAIL rstmid_outputs got %h want 0", all_outputs());
    end
    bad = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge PCLK);
      if (RSP_VALID !== 1'b0 || PSEL !== 1'b0) bad++;
    end
    nt++;
    if (bad !== 0) begin nf++; $display("FAIL rstmid_no_rsp got %0d bad cycles want 0", bad); end
    do_txn(1'b0, 16'd78, 32'd0, 4'hF, 1, 32'h7777_1111, 2'b00, 0, 1'b0, obs, viol, aw);
    exp = model(1'b0, 32'h7777_1111, 2'b00, 1);
    nt++;
    if (obs !== exp || viol !== 0) begin
      nf++;
      $display("FAIL rstmid_next got %h/%0d want %h/0", obs, viol, exp);
    end
  endtask

  task automatic test_random();
    rsp_t obs, exp; int viol, aw, waits;
    logic wr; logic [31:0] prd; logic [1:0] err;
    for (int n = 0; n < 24; n++) begin
      wr = 1'($urandom); prd = $urandom; err = 2'($urandom);
      waits = $urandom_range(0, TMO + 4);
      do_txn(wr, 16'($urandom), $urandom, 4'($urandom), waits, prd, err,
             $urandom_range(0, 3), 1'b0, obs, viol, aw);
      exp = model(wr, prd, err, waits);
      nt++;
      if (obs !== exp) begin nf++; $display("FAIL rand%0d_rsp got %h want %h (waits %0d)", n, obs, exp, waits); end
      nt++;
      if (viol !== 0) begin nf++; $display("FAIL rand%0d_protocol got %0d violations want 0", n, viol); end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_write();
    test_read_wait();
    test_slave_err();
    test_timeout();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", nt, nf);
    $finish;
  end

endmodule
